// File: rtl/seq_det_arb_pkg.sv
// Shared types and constants for the sequence-detector arbiter.
// Holds the FSM state encoding and the "101" pattern match helper.
package seq_det_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [2:0] PATTERN = 3'b101;

   // True when the two previous bits plus the new bit form the pattern.
   function automatic logic pat_match(input logic [1:0] hist, input logic b);
      return {hist, b} == PATTERN;
   endfunction

endpackage

// File: rtl/pattern_det_101.sv
// Overlapping "101" serial detector with synchronous clear.
// The hit output is registered: it is high the cycle after the completing bit.
module pattern_det_101
   import seq_det_arb_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic bit_in,
   output logic hit
);

   logic [1:0] hist;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hist <= '0;
         hit  <= 1'b0;
      end else if (clr) begin
         hist <= '0;
         hit  <= 1'b0;
      end else begin
         hist <= {hist[0], bit_in};
         hit  <= pat_match(hist, bit_in);
      end
   end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin scheduler sharing one "101" detector among NUM_SRC serial sources.
// Grants one burst at a time, flushes the detector between owners, reports hits.
module seq_det_arbiter
   import seq_det_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned LEN_W   = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_SRC-1:0]         req,
   input  logic [NUM_SRC*LEN_W-1:0]   len,
   input  logic [NUM_SRC-1:0]         bit_in,
   output logic [NUM_SRC-1:0]         grant,
   output logic                       busy,
   output logic                       det_out,
   output logic                       burst_done,
   output logic [$clog2(NUM_SRC)-1:0] done_src,
   output logic [CNT_W-1:0]           done_hits
);

   localparam int unsigned        IDX_W   = $clog2(NUM_SRC);
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;
   localparam logic [NUM_SRC-1:0] ONE_HOT = NUM_SRC'(1);

   // First requester found scanning upward from ptr, wrapping at NUM_SRC.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                                input logic [IDX_W-1:0]   ptr);
      logic [IDX_W-1:0] pick;
      logic             found;
      int unsigned      idx;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         idx = (32'(ptr) + k) % NUM_SRC;
         if (!found && r[IDX_W'(idx)]) begin
            pick  = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   win_c;
   logic [LEN_W-1:0]   bit_cnt;
   logic [CNT_W-1:0]   hit_cnt;
   logic [CNT_W-1:0]   hit_inc_c;
   logic [1:0]         hist;
   logic               feed_c;
   logic               clr_c;
   logic               match_c;
   logic [NUM_SRC-1:0] grant_nxt;
   logic               burst_done_nxt;
   logic [LEN_W-1:0]   len_arr [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_len
      assign len_arr[i] = len[i*LEN_W +: LEN_W];
   end

   assign win_c = rr_pick(req, rr_ptr);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = '0;
      burst_done_nxt = 1'b0;
      clr_c          = 1'b0;
      feed_c         = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = FLUSH;
               grant_nxt = ONE_HOT << win_c;
            end
         end
         FLUSH: begin
            clr_c     = 1'b1;
            grant_nxt = grant;
            state_nxt = STREAM;
         end
         STREAM: begin
            feed_c    = bit_in[owner];
            grant_nxt = grant;
            if (bit_cnt == '0) begin
               state_nxt      = DONE;
               grant_nxt      = '0;
               burst_done_nxt = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Shadow of the detector history so hit_cnt advances on the completing edge.
   always_comb begin
      match_c   = (state == STREAM) && pat_match(hist, feed_c);
      hit_inc_c = hit_cnt;
      if (match_c && (hit_cnt != CNT_MAX)) begin
         hit_inc_c = hit_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         owner   <= '0;
         rr_ptr  <= '0;
         bit_cnt <= '0;
         hit_cnt <= '0;
         hist    <= '0;
      end else begin
         hist <= (state == FLUSH) ? 2'b00 : {hist[0], feed_c};
         if ((state == IDLE) && (|req)) begin
            owner   <= win_c;
            bit_cnt <= len_arr[win_c];
            hit_cnt <= '0;
         end else if (state == STREAM) begin
            bit_cnt <= bit_cnt - LEN_W'(1);
            hit_cnt <= hit_inc_c;
         end
         if (state == DONE) begin
            rr_ptr <= IDX_W'((32'(owner) + 32'd1) % NUM_SRC);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grant      <= '0;
         busy       <= 1'b0;
         burst_done <= 1'b0;
         done_src   <= '0;
         done_hits  <= '0;
      end else begin
         grant      <= grant_nxt;
         busy       <= (state_nxt != IDLE);
         burst_done <= burst_done_nxt;
         if (burst_done_nxt) begin
            done_src  <= owner;
            done_hits <= hit_inc_c;
         end
      end
   end

   pattern_det_101 u_det (
      .clock  (clock),
      .reset  (reset),
      .clr    (clr_c),
      .bit_in (feed_c),
      .hit    (det_out)
   );

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter: a wide-counter and a 2-bit-counter instance
// share stimulus; burst results go through a scoreboard queue.
module tb_seq_det_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] len;
   logic [3:0]  bit_in;

   logic [3:0]  grant,      grant2;
   logic        busy,       busy2;
   logic        det_out,    det_out2;
   logic        burst_done, burst_done2;
   logic [1:0]  done_src,   done_src2;
   logic [7:0]  done_hits;
   logic [1:0]  done_hits2;

   typedef struct {
      int src;
      int hits;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   errors     = 0;
   int   checks     = 0;
   int   cycle      = 0;
   int   last_grant = 0;

   seq_det_arbiter #(.NUM_SRC(4), .LEN_W(4), .CNT_W(8)) u_dut (
      .clock(clock), .reset(reset), .req(req), .len(len), .bit_in(bit_in),
      .grant(grant), .busy(busy), .det_out(det_out), .burst_done(burst_done),
      .done_src(done_src), .done_hits(done_hits)
   );

   seq_det_arbiter #(.NUM_SRC(4), .LEN_W(4), .CNT_W(2)) u_sat (
      .clock(clock), .reset(reset), .req(req), .len(len), .bit_in(bit_in),
      .grant(grant2), .busy(busy2), .det_out(det_out2), .burst_done(burst_done2),
      .done_src(done_src2), .done_hits(done_hits2)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cycle <= cycle + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: each burst_done pops the oldest expected burst result.
   always @(negedge clock) begin
      if (reset === 1'b1 && burst_done === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected_done: observed done_src %0h expected no burst", done_src);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("done_src", 32'(done_src), mon_e.src);
            chk("done_hits", 32'(done_hits), mon_e.hits);
            chk("sat_burst_done", 32'(burst_done2), 1);
            chk("sat_done_src", 32'(done_src2), mon_e.src);
            chk("sat_done_hits", 32'(done_hits2), (mon_e.hits > 3) ? 3 : mon_e.hits);
         end
      end
   end

   task automatic wait_grant(input int src);
      logic [3:0] oh;
      int n;
      oh = 4'b0001 << src;
      n  = 0;
      while (grant === 4'b0000 && n < 60) begin
         @(negedge clock);
         n++;
      end
      chk("grant_rise", 32'(grant), 32'(oh));
      chk("sat_grant_rise", 32'(grant2), 32'(oh));
      chk("grant_busy", 32'(busy), 1);
   endtask

   task automatic run_burst(input int src, input int n, input logic [15:0] bits,
                            input int gap_exp, input bit drop_req);
      logic [3:0] oh;
      logic [1:0] h;
      logic       m_prev;
      int         hits;
      exp_t       e;
      oh = 4'b0001 << src;
      wait_grant(src);
      if (gap_exp != 0) chk("burst_gap", 32'(cycle - last_grant), 32'(gap_exp));
      last_grant = cycle;
      if (drop_req) req = 4'b0000;
      len[src*4 +: 4] = 4'($urandom);
      hits = 0;
      h    = 2'b00;
      for (int j = 0; j <= n; j++) begin
         if ({h, bits[j]} == 3'b101) hits++;
         h = {h[0], bits[j]};
      end
      e.src  = src;
      e.hits = hits;
      sb.push_back(e);
      h      = 2'b00;
      m_prev = 1'b0;
      for (int j = 0; j <= n; j++) begin
         @(negedge clock);
         chk("stream_grant", 32'(grant), 32'(oh));
         chk("stream_busy", 32'(busy), 1);
         chk("stream_burst_done", 32'(burst_done), 0);
         chk("det_out", 32'(det_out), 32'(m_prev));
         chk("sat_det_out", 32'(det_out2), 32'(m_prev));
         bit_in      = 4'($urandom);
         bit_in[src] = bits[j];
         m_prev = ({h, bits[j]} == 3'b101);
         h      = {h[0], bits[j]};
      end
      @(negedge clock);
      chk("done_det_out", 32'(det_out), 32'(m_prev));
      chk("done_pulse", 32'(burst_done), 1);
      chk("done_grant", 32'(grant), 0);
      chk("done_busy", 32'(busy), 1);
   endtask

   initial begin
      logic [15:0] rb;
      reset  = 1'b1;
      req    = 4'b1111;
      len    = {4{4'd2}};
      bit_in = 4'b0000;
      #1 reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_det_out", 32'(det_out), 0);
      chk("rst_burst_done", 32'(burst_done), 0);
      chk("rst_done_src", 32'(done_src), 0);
      chk("rst_done_hits", 32'(done_hits), 0);
      chk("rst_sat_grant", 32'(grant2), 0);
      req   = 4'b0000;
      reset = 1'b1;
      @(negedge clock);
      chk("idle_busy", 32'(busy), 0);

      // Fairness: all requesting, len 2, five back-to-back bursts
      req = 4'b1111;
      rb = 16'($urandom); run_burst(0, 2, rb, 0, 1'b0);
      rb = 16'($urandom); run_burst(1, 2, rb, 6, 1'b0);
      rb = 16'($urandom); run_burst(2, 2, rb, 6, 1'b0);
      rb = 16'($urandom); run_burst(3, 2, rb, 6, 1'b0);
      len = {4{4'd2}};
      rb = 16'($urandom); run_burst(0, 2, rb, 6, 1'b1);
      @(negedge clock);
      chk("post_fair_busy", 32'(busy), 0);
      chk("post_fair_grant", 32'(grant), 0);

      // Single burst on source 0: bits 0,1,0,1,0,1,1
      len[3:0] = 4'd6;
      req      = 4'b0001;
      run_burst(0, 6, 16'h006A, 0, 1'b1);
      @(negedge clock);

      // Boundary isolation: source 1 ends "10", source 2 starts "1"
      len[7:4]  = 4'd3;
      len[11:8] = 4'd2;
      req       = 4'b0110;
      run_burst(1, 3, 16'h0005, 0, 1'b0);
      run_burst(2, 2, 16'h0005, 7, 1'b1);
      @(negedge clock);

      // Mid-burst reset on source 3, then rr pointer restarts at 0
      len[15:12] = 4'd5;
      req        = 4'b1000;
      wait_grant(3);
      req = 4'b0000;
      repeat (3) begin
         @(negedge clock);
         bit_in = 4'($urandom);
      end
      reset = 1'b0;
      #1;
      chk("abort_grant", 32'(grant), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_det_out", 32'(det_out), 0);
      chk("abort_burst_done", 32'(burst_done), 0);
      chk("abort_done_src", 32'(done_src), 0);
      chk("abort_done_hits", 32'(done_hits), 0);
      chk("abort_sat_grant", 32'(grant2), 0);
      req      = 4'b1010;
      len[7:4] = 4'd2;
      @(negedge clock);
      reset = 1'b1;
      rb = 16'($urandom); run_burst(1, 2, rb, 0, 1'b1);
      @(negedge clock);

      // Saturation: 5 hits, the 2-bit instance reports 3
      len[11:8] = 4'd10;
      req       = 4'b0100;
      run_burst(2, 10, 16'h0555, 0, 1'b1);

      repeat (2) @(negedge clock);
      chk("sb_empty", 32'(sb.size()), 0);
      chk("end_busy", 32'(busy), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/seq_det_arbiter.md
# seq_det_arbiter

Round-robin controller that shares one serial "101" pattern detector among NUM_SRC serial bit sources. Each source requests the detector for a burst of programmable length. The controller grants one source at a time, clears the detector between bursts so no pattern spans two owners, and reports per-burst hit counts. It sits in front of the sequence-detector datapath as its scheduler.

## Interface
- NUM_SRC, 4: number of requesting sources (2..8)
- LEN_W, 4: width of per-source burst length field; burst = len+1 bits
- CNT_W, 8: width of hit counter (saturating)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_SRC  per-source request level
- len  in  NUM_SRC*LEN_W  packed burst lengths; source i at [i*LEN_W +: LEN_W]
- bit_in  in  NUM_SRC  per-source serial data lane
- grant  out  NUM_SRC  one-hot grant; all-zero when no owner
- busy  out  1  high in any non-IDLE state
- det_out  out  1  one-cycle pulse per detected "101"
- burst_done  out  1  one-cycle pulse at end of burst
- done_src  out  $clog2(NUM_SRC)  owner of completed burst; valid with burst_done
- done_hits  out  CNT_W  hits in completed burst; valid with burst_done

## Operation
- FSM states: IDLE, FLUSH, STREAM, DONE.
- IDLE: if any req is high at the clock edge, pick the winner by round-robin starting at rr_ptr, latch its index and len into bit_cnt, clear hit_cnt, and go to FLUSH. Otherwise stay in IDLE.
- FLUSH (1 cycle): grant[winner]=1; detector synchronous clear asserted; go to STREAM.
- STREAM (len+1 cycles): grant held. bit_in[winner] is sampled at each edge and fed to the detector. bit_cnt decrements. Leave for DONE at the edge that samples the bit with bit_cnt==0.
- DONE (1 cycle): grant=0, burst_done=1, done_src=winner, done_hits=hit_cnt. Set rr_ptr=(winner+1) mod NUM_SRC. Go to IDLE.
- Detector: overlapping "101" match. A match completed by the bit sampled at edge k gives det_out=1 in cycle k+1, and hit_cnt increments at edge k. hit_cnt saturates at 2^CNT_W-1.
- req is only examined in IDLE. Deasserting req during FLUSH or STREAM does not shorten the burst. The len input is ignored after it is latched.
- Reset (async, active-low): state=IDLE, rr_ptr=0, the detector is cleared, and all outputs go to 0: grant=0, busy=0, det_out=0, burst_done=0, done_src=0, done_hits=0.
- Reset asserted mid-burst aborts the burst. No burst_done is produced.

## Timing
- grant rises on the edge leaving IDLE. The source must present bit j during STREAM cycle j. Bit 0 is sampled at the 2nd edge after grant rises.
- Occupancy per burst: len+4 cycles (IDLE, FLUSH, len+1 STREAM, DONE). Back-to-back bursts therefore have exactly one IDLE cycle between them.
- The final bit's det_out pulse coincides with burst_done. done_hits includes that final hit.
- No combinational path from req or bit_in to any output. All outputs are registered.

## Structure
- Package seq_det_arb_pkg holds the state enum (IDLE/FLUSH/STREAM/DONE) and the pattern constant 3'b101.
- Sub-module pattern_det_101 has ports clock, reset, clr, bit_in, hit. It is an overlapping detector with synchronous clear and a registered hit output.
- Round-robin pick is a combinational function in the top module.

## Test plan
- Reset: hold reset low with req=4'b1111 -> grant=0, busy=0, det_out=0, burst_done=0, done_hits=0.
- Single burst: req[0]=1, len0=6, bits 0,1,0,1,0,1,1 -> det_out pulses after bits 3 and 5; burst_done with done_src=0, done_hits=2.
- Fairness: req=4'b1111 held, all len=2 -> grants in order 0,1,2,3,0. Each burst occupies 6 cycles.
- Boundary isolation: source 1 ends its burst with "...10", then source 2 starts with "1..." -> no det_out at the boundary; each done_hits counts only its own burst.
- Saturation (CNT_W=2): len=10, bits 1,0,1,0,1,0,1,0,1,0,1 -> 5 det_out pulses; done_hits=3.
- Mid-burst reset: assert reset in the 3rd STREAM cycle -> grant and all outputs go to 0 immediately, with no burst_done. After release with req=4'b1010, source 1 is granted first (rr_ptr=0).
